// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - Kyber constants and types shared by the CBD sampler
package kyber_pkg;

    localparam int KYBER_N    = 256;
    localparam int KYBER_K    = 3;
    localparam int KYBER_ETA1 = 2;
    localparam int COEF_W     = 3;

    typedef logic signed [COEF_W-1:0] cbd_coef_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } cbd_state_t;

endpackage

// File: rtl/cbd2_coef.sv
// rtl/cbd2_coef.sv - eta=2 centered-binomial decode of one nibble into a signed coefficient
module cbd2_coef
    import kyber_pkg::*;
(
    input  logic [3:0] nibble,
    output cbd_coef_t  coef
);

    logic [1:0] a;
    logic [1:0] b;

    assign a    = {1'b0, nibble[0]} + {1'b0, nibble[1]};
    assign b    = {1'b0, nibble[2]} + {1'b0, nibble[3]};
    assign coef = cbd_coef_t'({1'b0, a} - {1'b0, b});

endmodule

// File: rtl/cbd_sampler.sv
// rtl/cbd_sampler.sv - CBD eta=2 sampler filling K polynomials from a PRF word stream
// Optional feature: CBD_PIPE_EN registers the accepted word and writes it one cycle later.
module cbd_sampler
    import kyber_pkg::*;
#(
    parameter int K    = KYBER_K,
    parameter int N    = KYBER_N,
    parameter int IN_W = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [COEF_W*N-1:0]   r [K],
    output logic                  busy,
    output logic                  done
);

    localparam int CPW   = IN_W / 4;
    localparam int WPP   = N / CPW;
    localparam int WW    = (WPP > 1) ? $clog2(WPP) : 1;
    localparam int PW    = (K > 1) ? $clog2(K) : 1;
    localparam int SLICE = CPW * COEF_W;

    cbd_state_t        state_q;
    cbd_state_t        state_d;
    logic [WW-1:0]     word_idx;
    logic [PW-1:0]     poly_idx;
    logic              accept;
    logic              last_word;
    logic [IN_W-1:0]   dec_src;
    logic [SLICE-1:0]  dec_word;
    logic              wr_en;
    logic [WW-1:0]     wr_word;
    logic [PW-1:0]     wr_poly;
    logic              fill_end;
    logic              drain;

    // A start in the same cycle as a handshake discards that word.
    assign accept    = in_valid && in_ready && !start;
    assign last_word = (poly_idx == PW'(K - 1)) && (word_idx == WW'(WPP - 1));

`ifdef CBD_PIPE_EN
    logic              pipe_valid;
    logic              pipe_last;
    logic [IN_W-1:0]   pipe_data;
    logic [WW-1:0]     pipe_word;
    logic [PW-1:0]     pipe_poly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_last  <= 1'b0;
            pipe_data  <= '0;
            pipe_word  <= '0;
            pipe_poly  <= '0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_last <= last_word;
                pipe_data <= in_data;
                pipe_word <= word_idx;
                pipe_poly <= poly_idx;
            end
        end
    end

    assign dec_src  = pipe_data;
    assign wr_en    = pipe_valid && !start;
    assign wr_word  = pipe_word;
    assign wr_poly  = pipe_poly;
    assign fill_end = pipe_valid && pipe_last;
    // Final word is in flight: stop accepting while it drains.
    assign drain    = pipe_valid && pipe_last;
`else
    assign dec_src  = in_data;
    assign wr_en    = accept;
    assign wr_word  = word_idx;
    assign wr_poly  = poly_idx;
    assign fill_end = accept && last_word;
    assign drain    = 1'b0;
`endif

    for (genvar j = 0; j < CPW; j++) begin : g_dec
        cbd2_coef u_coef (
            .nibble (dec_src[4*j +: 4]),
            .coef   (dec_word[COEF_W*j +: COEF_W])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            poly_idx <= '0;
        end else if (start) begin
            word_idx <= '0;
            poly_idx <= '0;
        end else if (accept) begin
            if (word_idx == WW'(WPP - 1)) begin
                word_idx <= '0;
                poly_idx <= last_word ? '0 : poly_idx + 1'b1;
            end else begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                r[k] <= '0;
            end
        end else if (wr_en) begin
            r[wr_poly][wr_word*SLICE +: SLICE] <= dec_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (!start && fill_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == FILL);
    assign done     = (state_q == DONE);
    assign in_ready = (state_q == FILL) && !drain;

endmodule
